// File: rtl/line_tool.sv
// Bresenham line tool: press latches the anchor, release latches the end point, then one pixel per clock.
// Optional right-button abort is compiled in with LINE_TOOL_CANCEL_EN.
module line_tool #(
    parameter int                     WIDTH       = 640,
    parameter int                     HEIGHT      = 480,
    parameter int                     COLOR_WIDTH = 3,
    parameter logic [COLOR_WIDTH-1:0] COLOR_NONE  = '0,
    localparam int                    XW          = $clog2(WIDTH),
    localparam int                    YW          = $clog2(HEIGHT)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [XW-1:0]          cursor_x,
    input  logic [YW-1:0]          cursor_y,
    input  logic [COLOR_WIDTH-1:0] input_color,
`ifdef LINE_TOOL_CANCEL_EN
    input  logic                   cancel,
`endif
    output logic [XW-1:0]          pixel_x,
    output logic [YW-1:0]          pixel_y,
    output logic [COLOR_WIDTH-1:0] pixel_color,
    output logic                   pixel_valid,
    output logic                   busy
);

    localparam int SW = ((XW > YW) ? XW : YW) + 2;

    typedef enum logic [1:0] {IDLE, HOLD, SETUP, DRAW} state_t;

    state_t                  state_q;
    logic                    enable_prev_q;
    logic [XW-1:0]           x0_q, x1_q, cur_x_q, last_x_q;
    logic [YW-1:0]           y0_q, y1_q, cur_y_q, last_y_q;
    logic [COLOR_WIDTH-1:0]  color_q;
    logic signed [SW-1:0]    dx_q, dy_q, err_q;
    logic                    sx_neg_q, sy_neg_q;

    logic                    cancel_req;
    logic [XW-1:0]           dx_abs, cur_x_d;
    logic [YW-1:0]           dy_abs, cur_y_d;
    logic signed [SW-1:0]    dx_s, dy_s, e2, err_d;
    logic                    at_end;

`ifdef LINE_TOOL_CANCEL_EN
    assign cancel_req = cancel;
`else
    assign cancel_req = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        dx_abs  = (x1_q >= x0_q) ? x1_q - x0_q : x0_q - x1_q;
        dy_abs  = (y1_q >= y0_q) ? y1_q - y0_q : y0_q - y1_q;
        dx_s    = {{(SW-XW){1'b0}}, dx_abs};
        dy_s    = -{{(SW-YW){1'b0}}, dy_abs};
        at_end  = (cur_x_q == x1_q) && (cur_y_q == y1_q);
        // Both Bresenham tests use e2 taken from the error before this step's updates.
        e2      = err_q <<< 1;
        err_d   = err_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        if (e2 >= dy_q) begin
            err_d   = err_d + dy_q;
            cur_x_d = sx_neg_q ? cur_x_q - XW'(1) : cur_x_q + XW'(1);
        end
        if (e2 <= dx_q) begin
            err_d   = err_d + dx_q;
            cur_y_d = sy_neg_q ? cur_y_q - YW'(1) : cur_y_q + YW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: only control and output-visible registers are reset; endpoints and Bresenham
            // terms are always loaded before they are read.
            state_q       <= IDLE;
            enable_prev_q <= 1'b0;
            last_x_q      <= '0;
            last_y_q      <= '0;
        end else begin
            enable_prev_q <= enable;
            case (state_q)
                IDLE: begin
                    if (enable && !enable_prev_q) begin
                        x0_q    <= cursor_x;
                        y0_q    <= cursor_y;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (cancel_req) begin
                        state_q <= IDLE;
                    end else if (!enable) begin
                        x1_q    <= cursor_x;
                        y1_q    <= cursor_y;
                        color_q <= input_color;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    dx_q     <= dx_s;
                    dy_q     <= dy_s;
                    err_q    <= dx_s + dy_s;
                    sx_neg_q <= (x1_q < x0_q);
                    sy_neg_q <= (y1_q < y0_q);
                    cur_x_q  <= x0_q;
                    cur_y_q  <= y0_q;
                    state_q  <= cancel_req ? IDLE : DRAW;
                end
                DRAW: begin
                    // Remember the emitted pixel so the outputs hold it once drawing stops.
                    last_x_q <= cur_x_q;
                    last_y_q <= cur_y_q;
                    if (at_end || cancel_req) begin
                        state_q <= IDLE;
                    end else begin
                        cur_x_q <= cur_x_d;
                        cur_y_q <= cur_y_d;
                        err_q   <= err_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pixel_valid = (state_q == DRAW);
    assign busy        = (state_q == SETUP) || (state_q == DRAW);
    assign pixel_color = pixel_valid ? color_q : COLOR_NONE;
    assign pixel_x     = pixel_valid ? cur_x_q : last_x_q;
    assign pixel_y     = pixel_valid ? cur_y_q : last_y_q;

endmodule

// File: tb/tb_line_tool.sv
// Directed bench for line_tool: drags with hand-computed Bresenham pixel lists, reset and edge cases.
// Cancel scenario is exercised only when LINE_TOOL_CANCEL_EN is defined.
module tb_line_tool;

    localparam int              XW         = 10;
    localparam int              YW         = 9;
    localparam int              CW         = 3;
    localparam logic [CW-1:0]   COLOR_NONE = 3'd0;
    localparam int              CAP        = 40;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [XW-1:0] cursor_x;
    logic [YW-1:0] cursor_y;
    logic [CW-1:0] input_color;
    logic          cancel;
    logic [XW-1:0] pixel_x;
    logic [YW-1:0] pixel_y;
    logic [CW-1:0] pixel_color;
    logic          pixel_valid;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic          cap_v [CAP];
    logic          cap_b [CAP];
    logic [XW-1:0] cap_x [CAP];
    logic [YW-1:0] cap_y [CAP];
    logic [CW-1:0] cap_c [CAP];

    line_tool #(
        .WIDTH(640), .HEIGHT(480), .COLOR_WIDTH(CW), .COLOR_NONE(COLOR_NONE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .cursor_x    (cursor_x),
        .cursor_y    (cursor_y),
        .input_color (input_color),
`ifdef LINE_TOOL_CANCEL_EN
        .cancel      (cancel),
`endif
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_color (pixel_color),
        .pixel_valid (pixel_valid),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Press at (ax,ay), wander to (100,100) while held, release at (bx,by) with color col.
    task automatic drag(input int ax, input int ay, input int bx, input int by, input logic [CW-1:0] col);
        @(negedge clk);
        cursor_x = XW'(ax); cursor_y = YW'(ay); enable = 1'b1;
        repeat (2) begin
            @(negedge clk);
            cursor_x = XW'(100); cursor_y = YW'(100);
        end
        @(negedge clk);
        cursor_x = XW'(bx); cursor_y = YW'(by); enable = 1'b0; input_color = col;
    endtask

    // Record n cycles of outputs starting with the release edge; disturb color and cursor afterwards.
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cap_v[i] = pixel_valid; cap_b[i] = busy;
            cap_x[i] = pixel_x; cap_y[i] = pixel_y; cap_c[i] = pixel_color;
            if (i == 0) begin
                input_color = 3'd7; cursor_x = XW'(200); cursor_y = YW'(200);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; cancel = 1'b0;
        cursor_x = '0; cursor_y = '0; input_color = 3'd1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (pixel_valid !== 1'b0 || busy !== 1'b0 || pixel_color !== COLOR_NONE ||
            pixel_x !== '0 || pixel_y !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b b=%b c=%0d (%0d,%0d), expected v=0 b=0 c=%0d (0,0)",
                     pixel_valid, busy, pixel_color, pixel_x, pixel_y, COLOR_NONE);
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (pixel_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got v=%b b=%b, expected v=0 b=0", pixel_valid, busy);
        end
    endtask

    task automatic test_horizontal();
        int ex[5] = '{10, 11, 12, 13, 14};
        drag(10, 5, 14, 5, 3'd5);
        capture(8);
        n_checks++;
        if (cap_v[0] !== 1'b0 || cap_b[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL horiz_setup: got v=%b b=%b, expected v=0 b=1", cap_v[0], cap_b[0]);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (cap_v[i+1] !== 1'b1 || cap_x[i+1] !== XW'(ex[i]) || cap_y[i+1] !== YW'(5) || cap_c[i+1] !== 3'd5) begin
                n_fail++;
                $display("FAIL horiz_pixel %0d: got v=%b (%0d,%0d) c=%0d, expected v=1 (%0d,5) c=5",
                         i, cap_v[i+1], cap_x[i+1], cap_y[i+1], cap_c[i+1], ex[i]);
            end
        end
        n_checks++;
        if (cap_v[6] !== 1'b0 || cap_b[6] !== 1'b0 || cap_c[6] !== COLOR_NONE || cap_x[6] !== XW'(14) || cap_y[6] !== YW'(5)) begin
            n_fail++;
            $display("FAIL horiz_done: got v=%b b=%b c=%0d (%0d,%0d), expected v=0 b=0 c=0 (14,5)",
                     cap_v[6], cap_b[6], cap_c[6], cap_x[6], cap_y[6]);
        end
    endtask

    task automatic test_reverse();
        int ex[5] = '{14, 13, 12, 11, 10};
        drag(14, 5, 10, 5, 3'd3);
        capture(8);
        n_checks++;
        if (cap_v[0] !== 1'b0 || cap_b[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reverse_setup: got v=%b b=%b, expected v=0 b=1", cap_v[0], cap_b[0]);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (cap_v[i+1] !== 1'b1 || cap_x[i+1] !== XW'(ex[i]) || cap_y[i+1] !== YW'(5) || cap_c[i+1] !== 3'd3) begin
                n_fail++;
                $display("FAIL reverse_pixel %0d: got v=%b (%0d,%0d) c=%0d, expected v=1 (%0d,5) c=3",
                         i, cap_v[i+1], cap_x[i+1], cap_y[i+1], cap_c[i+1], ex[i]);
            end
        end
        n_checks++;
        if (cap_v[6] !== 1'b0 || cap_b[6] !== 1'b0 || cap_x[6] !== XW'(10)) begin
            n_fail++;
            $display("FAIL reverse_done: got v=%b b=%b x=%0d, expected v=0 b=0 x=10", cap_v[6], cap_b[6], cap_x[6]);
        end
    endtask

    task automatic test_diagonal();
        drag(0, 0, 3, 3, 3'd6);
        capture(7);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (cap_v[i+1] !== 1'b1 || cap_x[i+1] !== XW'(i) || cap_y[i+1] !== YW'(i) || cap_c[i+1] !== 3'd6) begin
                n_fail++;
                $display("FAIL diag_pixel %0d: got v=%b (%0d,%0d) c=%0d, expected v=1 (%0d,%0d) c=6",
                         i, cap_v[i+1], cap_x[i+1], cap_y[i+1], cap_c[i+1], i, i);
            end
        end
        n_checks++;
        if (cap_v[5] !== 1'b0 || cap_b[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL diag_done: got v=%b b=%b, expected v=0 b=0", cap_v[5], cap_b[5]);
        end
    endtask

    task automatic test_steep();
        int ex[6] = '{2, 2, 2, 3, 3, 3};
        int ey[6] = '{1, 2, 3, 4, 5, 6};
        drag(2, 1, 3, 6, 3'd2);
        capture(9);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (cap_v[i+1] !== 1'b1 || cap_x[i+1] !== XW'(ex[i]) || cap_y[i+1] !== YW'(ey[i]) || cap_c[i+1] !== 3'd2) begin
                n_fail++;
                $display("FAIL steep_pixel %0d: got v=%b (%0d,%0d) c=%0d, expected v=1 (%0d,%0d) c=2",
                         i, cap_v[i+1], cap_x[i+1], cap_y[i+1], cap_c[i+1], ex[i], ey[i]);
            end
        end
        n_checks++;
        if (cap_v[7] !== 1'b0 || cap_b[7] !== 1'b0 || cap_x[7] !== XW'(3) || cap_y[7] !== YW'(6)) begin
            n_fail++;
            $display("FAIL steep_done: got v=%b b=%b (%0d,%0d), expected v=0 b=0 (3,6)",
                     cap_v[7], cap_b[7], cap_x[7], cap_y[7]);
        end
    endtask

    task automatic test_single_pixel();
        drag(7, 7, 7, 7, 3'd4);
        @(posedge clk); #1;
        n_checks++;
        if (pixel_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_setup: got v=%b b=%b, expected v=0 b=1", pixel_valid, busy);
        end
        enable = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (pixel_valid !== 1'b1 || pixel_x !== XW'(7) || pixel_y !== YW'(7) || pixel_color !== 3'd4) begin
            n_fail++;
            $display("FAIL single_pixel: got v=%b (%0d,%0d) c=%0d, expected v=1 (7,7) c=4",
                     pixel_valid, pixel_x, pixel_y, pixel_color);
        end
        @(posedge clk); #1;
        n_checks++;
        if (pixel_valid !== 1'b0 || busy !== 1'b0 || pixel_color !== COLOR_NONE) begin
            n_fail++;
            $display("FAIL single_done: got v=%b b=%b c=%0d, expected v=0 b=0 c=0", pixel_valid, busy, pixel_color);
        end
        // Held button into IDLE must not anchor; a later release would otherwise start a line.
        repeat (3) @(posedge clk);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (busy !== 1'b0 || pixel_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL held_no_anchor %0d: got v=%b b=%b, expected v=0 b=0", i, pixel_valid, busy);
            end
        end
    endtask

    task automatic test_reset_mid_draw();
        drag(0, 0, 20, 0, 3'd5);
        @(posedge clk); #1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (pixel_valid !== 1'b1 || pixel_x !== XW'(2) || pixel_y !== YW'(0)) begin
            n_fail++;
            $display("FAIL middraw_third: got v=%b (%0d,%0d), expected v=1 (2,0)", pixel_valid, pixel_x, pixel_y);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (pixel_valid !== 1'b0 || busy !== 1'b0 || pixel_color !== COLOR_NONE || pixel_x !== '0) begin
            n_fail++;
            $display("FAIL middraw_reset: got v=%b b=%b c=%0d x=%0d, expected v=0 b=0 c=0 x=0",
                     pixel_valid, busy, pixel_color, pixel_x);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (pixel_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL middraw_no_resume %0d: got v=%b b=%b, expected v=0 b=0", i, pixel_valid, busy);
            end
        end
    endtask

    task automatic test_cancel_hold();
        @(negedge clk);
        cursor_x = XW'(1); cursor_y = YW'(1); enable = 1'b1;
        @(negedge clk); cancel = 1'b1;
        @(negedge clk); cancel = 1'b0; enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (pixel_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL cancel_hold %0d: got v=%b b=%b, expected v=0 b=0", i, pixel_valid, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_horizontal();
        test_reverse();
        test_diagonal();
        test_steep();
        test_single_pixel();
        test_reset_mid_draw();
`ifdef LINE_TOOL_CANCEL_EN
        test_cancel_hold();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
